// File: rtl/rr_sched_pkg.sv
// Shared constants and state encoding for the round-robin channel scheduler.
package rr_sched_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from ptr+1, wrapping 3->0.
module rr_pick
    import rr_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   winner,
    output logic               valid
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        valid  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/rr_channel_sched.sv
// Round-robin owner scheduler for a shared 4:1 mux / 1:4 demux, all outputs registered.
// Optional forced release after HOLD_MAX grant cycles when RR_SCHED_TIMEOUT_EN is defined.
module rr_channel_sched
    import rr_sched_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [SEL_W-1:0]   sel,
    output logic               mux_en,
    output logic               demux_en,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy,
    output logic               timeout
);

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
        $error("HOLD_MAX must be within 1..255");
    end

    state_t             state, state_nx;
    logic [SEL_W-1:0]   ptr, ptr_nx;
    logic [SEL_W-1:0]   sel_nx;
    logic [SEL_W-1:0]   win;
    logic               win_valid;
    logic [CNT_W-1:0]   hold_cnt, hold_nx;
    logic [NUM_REQ-1:0] gnt_nx;
    logic               en_nx;
    logic               busy_nx;
    logic               timeout_nx;
    logic               owner_exit;
    logic               force_rel;

    rr_pick u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (win),
        .valid  (win_valid)
    );

    // sel always holds the current owner while in GRANT
    assign owner_exit = done | ~req[sel];

`ifdef RR_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    assign force_rel = (state == GRANT) && !owner_exit && (hold_cnt == HOLD_LAST);
`else
    assign force_rel = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= SEL_W'(NUM_REQ - 1);
            hold_cnt <= '0;
            sel      <= '0;
            gnt      <= '0;
            mux_en   <= 1'b0;
            demux_en <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            hold_cnt <= hold_nx;
            sel      <= sel_nx;
            gnt      <= gnt_nx;
            mux_en   <= en_nx;
            demux_en <= en_nx;
            busy     <= busy_nx;
            timeout  <= timeout_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (win_valid) state_nx = GRANT;
            GRANT:   if (owner_exit || force_rel) state_nx = RELEASE;
            RELEASE: state_nx = win_valid ? GRANT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values for the registered outputs, derived from the upcoming state
    always_comb begin
        sel_nx     = sel;
        ptr_nx     = ptr;
        hold_nx    = hold_cnt;
        gnt_nx     = '0;
        en_nx      = 1'b0;
        busy_nx    = (state_nx != IDLE);
        timeout_nx = force_rel;
        if (state_nx == GRANT) begin
            en_nx = 1'b1;
            if (state != GRANT) begin
                sel_nx  = win;
                ptr_nx  = win;
                hold_nx = '0;
            end else if (hold_cnt != '1) begin
                hold_nx = hold_cnt + 1'b1;
            end
            gnt_nx[sel_nx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_channel_sched.sv
// Scoreboard bench for rr_channel_sched: directed stimulus with expected outputs queued per edge.
module tb_rr_channel_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic       mux_en;
    logic       demux_en;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;

    logic [9:0] obsv;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    rr_channel_sched #(.HOLD_MAX(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .done     (done),
        .sel      (sel),
        .mux_en   (mux_en),
        .demux_en (demux_en),
        .gnt      (gnt),
        .busy     (busy),
        .timeout  (timeout)
    );

    assign obsv = {busy, timeout, mux_en, demux_en, sel, gnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] pk(input logic [3:0] g, input logic [1:0] s,
                                      input logic en, input logic b, input logic t);
        return {b, t, en, en, s, g};
    endfunction

    // expected output vectors: granted owner, release holding sel, idle holding sel
    function automatic logic [9:0] eg(input logic [1:0] o);
        logic [3:0] g;
        g = 4'b0001 << o;
        return pk(g, o, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic logic [9:0] er(input logic [1:0] s, input logic t);
        return pk(4'b0000, s, 1'b0, 1'b1, t);
    endfunction

    function automatic logic [9:0] ei(input logic [1:0] s);
        return pk(4'b0000, s, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic step(input string tag, input logic [3:0] r, input logic d, input logic [9:0] e);
        exp_t x;
        req   = r;
        done  = d;
        x.tag = tag;
        x.exp = e;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        chk(x.tag, 32'(obsv), 32'(x.exp));
    endtask

    task automatic do_reset(input string tag);
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        @(posedge clk);
        #1;
        chk(tag, 32'(obsv), 32'd0);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;

        // single requester, done on the third grant cycle
        do_reset("rst_init");
        step("single_g1", 4'b0001, 1'b0, eg(2'd0));
        step("single_g2", 4'b0001, 1'b0, eg(2'd0));
        step("single_g3", 4'b0001, 1'b0, eg(2'd0));
        step("single_rel", 4'b0000, 1'b1, er(2'd0, 1'b0));
        step("single_idle", 4'b0000, 1'b0, ei(2'd0));

        // all four requesting: strict rotation with one gap cycle between owners
        do_reset("rst_rot");
        for (int i = 0; i < 5; i++) begin
            step($sformatf("rot_g%0d", i), 4'b1111, 1'b0, eg(2'(i % 4)));
            step($sformatf("rot_r%0d", i), 4'b1111, 1'b1, er(2'(i % 4), 1'b0));
        end
        step("rot_idle", 4'b0000, 1'b0, ei(2'd0));

        // owner 2 not preempted, then drops its request: 3 wins over 0
        do_reset("rst_drop");
        step("drop_g2", 4'b0100, 1'b0, eg(2'd2));
        step("drop_nopre", 4'b1101, 1'b0, eg(2'd2));
        step("drop_rel", 4'b1001, 1'b0, er(2'd2, 1'b0));
        step("drop_g3", 4'b1001, 1'b0, eg(2'd3));
        step("drop_rel3", 4'b0000, 1'b1, er(2'd3, 1'b0));
        step("drop_idle", 4'b0000, 1'b0, ei(2'd3));

        // asynchronous reset in the middle of a grant
        do_reset("rst_async0");
        step("async_g1", 4'b0010, 1'b0, eg(2'd1));
        #3;
        rst = 1'b1;
        #1;
        chk("async_drop", 32'(obsv), 32'd0);
        @(posedge clk);
        #1;
        chk("async_hold", 32'(obsv), 32'd0);
        #2;
        rst = 1'b0;
        step("async_g0", 4'b0011, 1'b0, eg(2'd0));
        step("async_rel", 4'b0011, 1'b1, er(2'd0, 1'b0));
        step("async_g1b", 4'b0010, 1'b0, eg(2'd1));
        step("async_rel1", 4'b0000, 1'b1, er(2'd1, 1'b0));
        step("async_idle", 4'b0000, 1'b0, ei(2'd1));

        // long hold by owner 1 with owner 2 waiting
        do_reset("rst_hold");
        step("hold_g0", 4'b0110, 1'b0, eg(2'd1));
        for (int i = 1; i < 4; i++) begin
            step($sformatf("hold_g%0d", i), 4'b0110, 1'b0, eg(2'd1));
        end
`ifdef RR_SCHED_TIMEOUT_EN
        step("to_rel", 4'b0110, 1'b0, er(2'd1, 1'b1));
        step("to_g2", 4'b0110, 1'b0, eg(2'd2));
        step("to_rel2", 4'b0000, 1'b1, er(2'd2, 1'b0));
        step("to_idle", 4'b0000, 1'b0, ei(2'd2));
`else
        for (int i = 4; i < 300; i++) begin
            step($sformatf("hold_g%0d", i), 4'b0110, 1'b0, eg(2'd1));
        end
        chk("hold_sat", 32'(dut.hold_cnt), 32'd255);
        step("hold_rel", 4'b0110, 1'b1, er(2'd1, 1'b0));
        step("hold_g2", 4'b0110, 1'b0, eg(2'd2));
        step("hold_rel2", 4'b0000, 1'b1, er(2'd2, 1'b0));
        step("hold_idle", 4'b0000, 1'b0, ei(2'd2));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
